// File: rtl/ninjin_ddr_buffer.sv
// rtl/ninjin_ddr_buffer.sv - element memory port to DDR burst bridge with prefetch, ping-pong read and write-back buffers
module ninjin_ddr_buffer #(
    parameter int DWIDTH    = 16,
    parameter int BWIDTH    = 32,
    parameter int RATELOG   = 1,
    parameter int LSB       = 2,
    parameter int MEMSIZE   = 16,
    parameter int IMGSIZE   = 17,
    parameter int LWIDTH    = 16,
    parameter int BURST_MAX = 256
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     pre_req,
    input  logic [MEMSIZE-1:0]       pre_base,
    input  logic [LWIDTH-1:0]        read_len,
    input  logic [LWIDTH-1:0]        write_len,
    input  logic                     mem_we,
    input  logic [IMGSIZE-1:0]       mem_addr,
    input  logic signed [DWIDTH-1:0] mem_wdata,
    input  logic                     ddr_we,
    input  logic [MEMSIZE-1:0]       ddr_waddr,
    input  logic [BWIDTH-1:0]        ddr_wdata,
    input  logic [MEMSIZE-1:0]       ddr_raddr,
    output logic                     pre_ack,
    output logic                     ddr_req,
    output logic                     ddr_mode,
    output logic [MEMSIZE+LSB-1:0]   ddr_base,
    output logic [LWIDTH-1:0]        ddr_len,
    output logic [BWIDTH-1:0]        ddr_rdata,
    output logic signed [DWIDTH-1:0] mem_rdata,
    output logic [1:0]               probe_state
);
    localparam int BLOG = $clog2(BURST_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t state, state_n;

    logic [MEMSIZE-1:0] base_q, wbase, fill_base, fetch_addr, flush_addr;
    logic [LWIDTH-1:0]  rlen_q, wlen_q, rlen_w, wlen_w, pre_cnt, cur_seg;
    logic [LWIDTH-1:0]  r_seg, w_seg, fetch_seg, fetch_off, w_off;
    logic [IMGSIZE-1:0] r_eoff, r_woff, w_eoff, w_woff;
    logic               fill_pre, fill_sel;
    logic               rd_start, rd_last, rd_switch, fetch_go;
    logic               wr_act, wr_last, flush, pre_done;
    logic [BWIDTH-1:0]  rd_word;
    logic [BLOG-1:0]    fill_idx;
    logic [BLOG:0]      o_off;

    logic [BWIDTH-1:0] pre_buf [BURST_MAX];
    logic [BWIDTH-1:0] pp_buf  [2][BURST_MAX];

    function automatic logic [LWIDTH-1:0] clip(input logic [LWIDTH-1:0] n);
        return (n > LWIDTH'(BURST_MAX)) ? LWIDTH'(BURST_MAX) : n;
    endfunction

    assign rlen_w      = rlen_q >> RATELOG;
    assign wlen_w      = wlen_q >> RATELOG;
    assign wbase       = base_q + MEMSIZE'(rlen_w);
    assign probe_state = state;

    // Read side: segment 0 lives in the prefetch buffer, segment k>0 in pp_buf[~k[0]]
    assign r_eoff     = mem_addr - (IMGSIZE'(base_q) << RATELOG);
    assign r_woff     = r_eoff >> RATELOG;
    assign r_seg      = LWIDTH'(r_woff >> BLOG);
    assign rd_start   = (state == S_IDLE) && !mem_we && (r_eoff == '0) && (rlen_w != '0);
    assign rd_last    = (r_eoff == IMGSIZE'(rlen_q) - IMGSIZE'(1));
    assign rd_switch  = (state == S_READ) && !mem_we && (r_seg == cur_seg + LWIDTH'(1))
                        && (r_woff < IMGSIZE'(rlen_w));
    assign fetch_seg  = rd_start ? LWIDTH'(1) : r_seg + LWIDTH'(1);
    assign fetch_off  = fetch_seg << BLOG;
    assign fetch_go   = (rd_start || rd_switch) && (rlen_w > fetch_off);
    assign fetch_addr = base_q + MEMSIZE'(fetch_off);
    assign rd_word    = (r_woff < IMGSIZE'(BURST_MAX)) ? pre_buf[r_woff[BLOG-1:0]]
                                                        : pp_buf[~r_woff[BLOG]][r_woff[BLOG-1:0]];

    // Write side: segment k packs into pp_buf[k[0]] and is flushed when its last element lands
    assign w_eoff     = mem_addr - (IMGSIZE'(wbase) << RATELOG);
    assign w_woff     = w_eoff >> RATELOG;
    assign w_seg      = LWIDTH'(w_woff >> BLOG);
    assign w_off      = w_seg << BLOG;
    assign flush_addr = wbase + MEMSIZE'(w_off);
    assign wr_act     = mem_we && ((state == S_IDLE) || (state == S_WRITE))
                        && (w_eoff < IMGSIZE'(wlen_q));
    assign wr_last    = (w_eoff == IMGSIZE'(wlen_q) - IMGSIZE'(1));
    assign flush      = wr_act && (wr_last || (&w_eoff[RATELOG+BLOG-1:0]));

    assign pre_done   = (state == S_PRE)
                        && ((ddr_we && (pre_cnt + LWIDTH'(1) == ddr_len)) || (ddr_len == '0));
    assign fill_idx   = BLOG'(ddr_waddr - fill_base);
    assign o_off      = (BLOG+1)'(ddr_raddr - wbase);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (wr_act)
                    state_n = (flush && wr_last) ? S_IDLE : S_WRITE;
                else if (rd_start)
                    state_n = S_READ;
            end
            S_PRE:   if (pre_done) state_n = S_IDLE;
            S_READ:  if (!mem_we && rd_last) state_n = S_IDLE;
            S_WRITE: if (flush && wr_last) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (pre_req)
            state_n = S_PRE;
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            rlen_q    <= '0;
            wlen_q    <= '0;
            pre_cnt   <= '0;
            cur_seg   <= '0;
            fill_pre  <= 1'b0;
            fill_sel  <= 1'b0;
            fill_base <= '0;
            pre_ack   <= 1'b0;
            ddr_req   <= 1'b0;
            ddr_mode  <= 1'b0;
            ddr_base  <= '0;
            ddr_len   <= '0;
        end else begin
            state   <= state_n;
            ddr_req <= 1'b0;
            pre_ack <= pre_done && !pre_req;
            if (pre_req) begin
                base_q    <= pre_base;
                rlen_q    <= read_len;
                wlen_q    <= write_len;
                pre_cnt   <= '0;
                fill_pre  <= 1'b1;
                fill_base <= pre_base;
                ddr_req   <= 1'b1;
                ddr_mode  <= 1'b0;
                ddr_base  <= {pre_base, {LSB{1'b0}}};
                ddr_len   <= clip(read_len >> RATELOG);
            end else begin
                if (state == S_PRE && ddr_we)
                    pre_cnt <= pre_cnt + LWIDTH'(1);
                if (rd_start)
                    cur_seg <= '0;
                else if (rd_switch)
                    cur_seg <= r_seg;
                if (fetch_go) begin
                    fill_pre  <= 1'b0;
                    fill_sel  <= ~fetch_seg[0];
                    fill_base <= fetch_addr;
                    ddr_req   <= 1'b1;
                    ddr_mode  <= 1'b0;
                    ddr_base  <= {fetch_addr, {LSB{1'b0}}};
                    ddr_len   <= clip(rlen_w - fetch_off);
                end
                if (flush) begin
                    ddr_req  <= 1'b1;
                    ddr_mode <= 1'b1;
                    ddr_base <= {flush_addr, {LSB{1'b0}}};
                    ddr_len  <= clip(wlen_w - w_off);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ddr_we && fill_pre && state == S_PRE)
            pre_buf[fill_idx] <= ddr_wdata;
        if (ddr_we && !fill_pre)
            pp_buf[fill_sel][fill_idx] <= ddr_wdata;
        if (wr_act)
            pp_buf[w_woff[BLOG]][w_woff[BLOG-1:0]][w_eoff[RATELOG-1:0]*DWIDTH +: DWIDTH] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            mem_rdata <= '0;
            ddr_rdata <= '0;
        end else begin
            mem_rdata <= $signed(rd_word[r_eoff[RATELOG-1:0]*DWIDTH +: DWIDTH]);
            ddr_rdata <= pp_buf[o_off[BLOG]][o_off[BLOG-1:0]];
        end
    end
endmodule

// File: tb/tb_ninjin_ddr_buffer.sv
// tb/tb_ninjin_ddr_buffer.sv - directed self-checking bench for ninjin_ddr_buffer
module tb_ninjin_ddr_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               xrst, pre_req, mem_we, ddr_we;
    logic [15:0]        pre_base, read_len, write_len, ddr_waddr, ddr_raddr;
    logic [16:0]        mem_addr;
    logic signed [15:0] mem_wdata, mem_rdata;
    logic [31:0]        ddr_wdata, ddr_rdata;
    logic               pre_ack, ddr_req, ddr_mode;
    logic [17:0]        ddr_base;
    logic [15:0]        ddr_len;
    logic [1:0]         probe_state;

    int checks = 0, errors = 0;
    int rd_words = 0, wr_words = 0, wr_reqs = 0, pre_acks = 0;
    logic [17:0] last_rbase = '0, last_wbase = '0;
    logic [15:0] last_rlen = '0, last_wlen = '0;
    int          pat = 0;
    logic [15:0] pat_base = 16'h2800;
    int          feed_left = 0;
    logic [15:0] feed_addr = '0;

    ninjin_ddr_buffer dut (
        .clk(clk), .xrst(xrst), .pre_req(pre_req), .pre_base(pre_base),
        .read_len(read_len), .write_len(write_len), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ddr_we(ddr_we),
        .ddr_waddr(ddr_waddr), .ddr_wdata(ddr_wdata), .ddr_raddr(ddr_raddr),
        .pre_ack(pre_ack), .ddr_req(ddr_req), .ddr_mode(ddr_mode),
        .ddr_base(ddr_base), .ddr_len(ddr_len), .ddr_rdata(ddr_rdata),
        .mem_rdata(mem_rdata), .probe_state(probe_state)
    );

    function automatic logic [31:0] ddr_word(input logic [15:0] a);
        logic [15:0] off;
        off = a - pat_base;
        if (pat == 0) return 32'h0def000c + {16'h0, off};
        return {off ^ 16'ha5a5, off + 16'h0100};
    endfunction

    function automatic logic [15:0] exp_elem(input int i);
        logic [15:0] k;
        k = 16'(i >> 1);
        if (pat == 0) return (i % 2 == 1) ? 16'h0def : 16'h000c + k;
        return (i % 2 == 1) ? (k ^ 16'ha5a5) : (k + 16'h0100);
    endfunction

    // DDR side model: records requests and streams read bursts back
    initial begin
        ddr_we = 1'b0; ddr_waddr = '0; ddr_wdata = '0;
        forever begin
            @(negedge clk);
            if (pre_ack) pre_acks++;
            if (ddr_req && !ddr_mode) begin
                rd_words += int'(ddr_len);
                last_rbase = ddr_base; last_rlen = ddr_len;
                feed_addr = ddr_base[17:2]; feed_left = int'(ddr_len);
            end
            if (ddr_req && ddr_mode) begin
                wr_words += int'(ddr_len); wr_reqs++;
                last_wbase = ddr_base; last_wlen = ddr_len;
            end
            if (feed_left > 0) begin
                ddr_we = 1'b1; ddr_waddr = feed_addr; ddr_wdata = ddr_word(feed_addr);
                feed_addr++; feed_left--;
            end else begin
                ddr_we = 1'b0;
            end
        end
    end

    task automatic test_reset();
        xrst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pre_ack, ddr_req, ddr_mode} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {pre_ack, ddr_req, ddr_mode});
        end
        checks++;
        if (ddr_base !== 18'h0 || ddr_len !== 16'h0) begin
            errors++; $display("FAIL reset_base_len: got %h/%h want 0/0", ddr_base, ddr_len);
        end
        checks++;
        if (mem_rdata !== 16'sh0 || ddr_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h want 0/0", mem_rdata, ddr_rdata);
        end
        checks++;
        if (probe_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", probe_state);
        end
        xrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prefetch(input logic [15:0] base, input logic [15:0] rlen, input logic [15:0] wlen,
                                 input int p, input logic [17:0] exp_base, input logic [15:0] exp_len);
        int acks0;
        bit got;
        pat = p; pat_base = base;
        acks0 = pre_acks;
        @(negedge clk);
        pre_req = 1'b1; pre_base = base; read_len = rlen; write_len = wlen;
        @(negedge clk);
        pre_req = 1'b0;
        checks++;
        if (ddr_req !== 1'b1 || ddr_mode !== 1'b0) begin
            errors++; $display("FAIL pre_req_mode: got req=%b mode=%b want 1/0", ddr_req, ddr_mode);
        end
        checks++;
        if (ddr_base !== exp_base || ddr_len !== exp_len) begin
            errors++; $display("FAIL pre_burst: got base=%h len=%0d want %h/%0d", ddr_base, ddr_len, exp_base, exp_len);
        end
        checks++;
        if (probe_state !== 2'd1) begin
            errors++; $display("FAIL pre_state: got %0d want 1", probe_state);
        end
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (pre_acks != acks0) got = 1'b1;
        end
        checks++;
        if (!got || pre_acks != acks0 + 1) begin
            errors++; $display("FAIL pre_ack: got %0d pulses want 1", pre_acks - acks0);
        end
        @(negedge clk);
        checks++;
        if (probe_state !== 2'd0) begin
            errors++; $display("FAIL pre_idle: got %0d want 0", probe_state);
        end
    endtask

    task automatic test_read_pass(input int n, input int exp_words);
        int w0;
        w0 = rd_words;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_addr = 17'h05000 + 17'(i);
            @(negedge clk);
            checks++;
            if (mem_rdata !== exp_elem(i)) begin
                errors++; $display("FAIL read_elem[%0d]: got %h want %h", i, mem_rdata, exp_elem(i));
            end
            if (i == 1) begin
                checks++;
                if (probe_state !== 2'd2) begin
                    errors++; $display("FAIL read_state: got %0d want 2", probe_state);
                end
            end
            if (i % 7 == 3) @(negedge clk);
        end
        @(negedge clk);
        mem_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (probe_state !== 2'd0) begin
            errors++; $display("FAIL read_idle: got %0d want 0", probe_state);
        end
        checks++;
        if (rd_words - w0 != exp_words) begin
            errors++; $display("FAIL read_ddr_words: got %0d want %0d", rd_words - w0, exp_words);
        end
        if (exp_words > 0) begin
            checks++;
            if (last_rbase !== 18'h0a400 || last_rlen !== 16'd256) begin
                errors++; $display("FAIL read_fetch: got base=%h len=%0d want 0a400/256", last_rbase, last_rlen);
            end
        end
    endtask

    task automatic test_write(input int n, input logic [15:0] d0);
        int ws, wq;
        logic [31:0] expw;
        ws = wr_words; wq = wr_reqs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_we = 1'b1; mem_addr = 17'h05200 + 17'(i); mem_wdata = d0 + 16'(i);
            if (i == 2) begin
                checks++;
                if (probe_state !== 2'd3) begin
                    errors++; $display("FAIL write_state: got %0d want 3", probe_state);
                end
            end
        end
        @(negedge clk);
        mem_we = 1'b0; mem_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_reqs - wq != 1 || wr_words - ws != n / 2) begin
            errors++; $display("FAIL write_bursts: got %0d reqs %0d words want 1/%0d", wr_reqs - wq, wr_words - ws, n / 2);
        end
        checks++;
        if (last_wbase !== 18'h0a400 || last_wlen !== 16'd8) begin
            errors++; $display("FAIL write_burst: got base=%h len=%0d want 0a400/8", last_wbase, last_wlen);
        end
        checks++;
        if (probe_state !== 2'd0) begin
            errors++; $display("FAIL write_idle: got %0d want 0", probe_state);
        end
        for (int k = 0; k < n / 2; k++) begin
            @(negedge clk);
            ddr_raddr = 16'h2900 + 16'(k);
            @(negedge clk);
            expw = {d0 + 16'(2 * k + 1), d0 + 16'(2 * k)};
            checks++;
            if (ddr_rdata !== expw) begin
                errors++; $display("FAIL write_rdata[%0d]: got %h want %h", k, ddr_rdata, expw);
            end
        end
    endtask

    task automatic test_abort();
        int wq;
        wq = wr_reqs;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_we = 1'b1; mem_addr = 17'h05400 + 17'(i); mem_wdata = 16'(100 + i);
        end
        @(negedge clk);
        mem_we = 1'b0; mem_addr = '0;
        checks++;
        if (probe_state !== 2'd3) begin
            errors++; $display("FAIL abort_write_state: got %0d want 3", probe_state);
        end
        test_prefetch(16'h2800, 16'd512, 16'd16, 0, 18'h0a000, 16'd256);
        checks++;
        if (wr_reqs != wq) begin
            errors++; $display("FAIL abort_no_flush: got %0d write bursts want 0", wr_reqs - wq);
        end
    endtask

    initial begin
        int mark;
        xrst = 1'b0; pre_req = 1'b0; pre_base = '0; read_len = '0; write_len = '0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; ddr_raddr = '0;
        test_reset();
        test_prefetch(16'h2800, 16'd512, 16'd16, 0, 18'h0a000, 16'd256);
        test_read_pass(512, 0);
        test_write(16, 16'd5);
        test_read_pass(512, 0);
        test_write(16, 16'h0100);
        mark = rd_words;
        test_prefetch(16'h2800, 16'd1024, 16'd16, 1, 18'h0a000, 16'd256);
        test_read_pass(1024, 256);
        test_read_pass(1024, 256);
        checks++;
        if (rd_words - mark != 768) begin
            errors++; $display("FAIL read_total_1024: got %0d want 768", rd_words - mark);
        end
        test_abort();
        test_write(16, 16'h0300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
